// File: rtl/register_file_bist_ctrl_pkg.sv
// Shared types for the register-file March C- BIST controller.
// Defines the sequencer states, the background bit patterns and the order of March elements.
package register_file_bist_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_DRAIN,
    ST_DONE
  } regfile_bist_state_e;

  localparam logic BG0_BIT = 1'b0;
  localparam logic BG1_BIT = 1'b1;

  function automatic regfile_bist_state_e next_elem(input regfile_bist_state_e s);
    case (s)
      ST_M0:   return ST_M1;
      ST_M1:   return ST_M2;
      ST_M2:   return ST_M3;
      ST_M3:   return ST_M4;
      ST_M4:   return ST_M5;
      ST_M5:   return ST_DRAIN;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic logic elem_is_up(input regfile_bist_state_e s);
    return (s == ST_M0) || (s == ST_M1) || (s == ST_M2);
  endfunction

endpackage

// File: rtl/register_file_bist_ctrl_addr_gen.sv
// Up/down sweep counter over addresses 1..2**ADDR_WIDTH-1. It wraps without ever emitting 0 and flags the last address.
// Latency: the address changes one cycle after i_init or i_step. There is no backpressure, and i_init takes priority over i_step.
module regfile_bist_addr_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_init,
  input  logic                  i_init_up,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);

  localparam logic [ADDR_WIDTH-1:0] A_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] A_MIN = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_up   <= 1'b1;
    end else if (i_init) begin
      r_up   <= i_init_up;
      r_addr <= i_init_up ? A_MIN : A_MAX;
    end else if (i_step) begin
      if (r_up) r_addr <= (r_addr == A_MAX) ? A_MIN : r_addr + A_MIN;
      else      r_addr <= (r_addr == A_MIN) ? A_MAX : r_addr - A_MIN;
    end
  end

  assign o_addr = r_addr;
  assign o_last = r_up ? (r_addr == A_MAX) : (r_addr == A_MIN);

endmodule

// File: rtl/register_file_bist_ctrl.sv
// March C- BIST over register-file addresses 1..N-1. The first-fail log is built only when REGFILE_BIST_FAIL_LOG_EN is defined.
// Latency: 10*(N-1)+1 busy cycles from start_i to done_o. There is no backpressure: start_i is ignored while busy, and abort_i forces IDLE.
module register_file_bist_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  bist_o,
  output logic                  csn_t_o,
  output logic                  wen_t_o,
  output logic [ADDR_WIDTH-1:0] a_t_o,
  output logic [DATA_WIDTH-1:0] d_t_o,
  input  logic [DATA_WIDTH-1:0] q_t_i,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic [7:0]            fail_cnt_o
);
  import register_file_bist_ctrl_pkg::*;

  localparam logic [DATA_WIDTH-1:0] BG0 = {DATA_WIDTH{BG0_BIT}};
  localparam logic [DATA_WIDTH-1:0] BG1 = {DATA_WIDTH{BG1_BIT}};

  regfile_bist_state_e   r_state;
  logic                  r_phase;
  logic                  r_cmp_vld;
  logic [DATA_WIDTH-1:0] r_exp;
  logic                  r_pass;

  logic                  w_busy;
  logic                  w_start;
  logic                  w_rw_elem;
  logic                  w_rd_cyc;
  logic                  w_wr_cyc;
  logic                  w_elem_end;
  logic                  w_init;
  logic                  w_init_up;
  logic                  w_step;
  logic                  w_last;
  logic                  w_miscmp;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wr_bg;
  logic [DATA_WIDTH-1:0] w_rd_exp;

  assign w_busy    = !(r_state inside {ST_IDLE, ST_DONE});
  assign w_start   = !w_busy && start_i;
  assign w_rw_elem = r_state inside {ST_M1, ST_M2, ST_M3, ST_M4};
  // Read-then-write elements use phase 0 for the read and phase 1 for the write.
  assign w_rd_cyc  = (w_rw_elem && !r_phase) || (r_state == ST_M5);
  assign w_wr_cyc  = (w_rw_elem && r_phase) || (r_state == ST_M0);
  assign w_wr_bg   = (r_state inside {ST_M1, ST_M3}) ? BG1 : BG0;
  assign w_rd_exp  = (r_state inside {ST_M2, ST_M4}) ? BG1 : BG0;

  assign w_elem_end = w_last && (w_wr_cyc || (r_state == ST_M5));
  assign w_init     = w_start || (w_elem_end && (r_state != ST_M5));
  assign w_init_up  = w_start ? 1'b1 : elem_is_up(next_elem(r_state));
  assign w_step     = w_wr_cyc || (r_state == ST_M5);

  regfile_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_init    (w_init),
    .i_init_up (w_init_up),
    .i_step    (w_step),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  // q_t_i lags the read request by one cycle. Any write issued in that cycle has not landed yet.
  assign w_miscmp = r_cmp_vld && (q_t_i != r_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_phase   <= 1'b0;
      r_cmp_vld <= 1'b0;
      r_exp     <= '0;
      r_pass    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_state <= ST_M0;
            r_phase <= 1'b0;
            r_pass  <= 1'b1;
          end
        end
        ST_DRAIN: r_state <= ST_DONE;
        default: begin
          if (w_rw_elem) r_phase <= ~r_phase;
          if (w_elem_end) begin
            r_state <= next_elem(r_state);
            r_phase <= 1'b0;
          end
        end
      endcase
      if (w_busy && abort_i) begin
        r_state <= ST_IDLE;
        r_phase <= 1'b0;
      end
      r_cmp_vld <= w_rd_cyc && !abort_i;
      if (w_rd_cyc) r_exp <= w_rd_exp;
      if (w_miscmp) r_pass <= 1'b0;
    end
  end

  assign busy_o  = w_busy;
  assign bist_o  = w_busy;
  assign done_o  = (r_state == ST_DONE);
  assign pass_o  = (r_state == ST_DONE) && r_pass;
  assign csn_t_o = !(w_rd_cyc || w_wr_cyc);
  assign wen_t_o = !w_wr_cyc;
  assign a_t_o   = (w_rd_cyc || w_wr_cyc) ? w_addr : '0;
  assign d_t_o   = w_wr_cyc ? w_wr_bg : '0;

`ifdef REGFILE_BIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_data;
  logic [7:0]            r_fail_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_addr  <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_fail_cnt  <= '0;
    end else begin
      if (w_rd_cyc) r_cmp_addr <= w_addr;
      if (w_start) begin
        r_fail_addr <= '0;
        r_fail_data <= '0;
        r_fail_cnt  <= '0;
      end else if (w_miscmp) begin
        if (r_fail_cnt == 8'd0) begin
          r_fail_addr <= r_cmp_addr;
          r_fail_data <= q_t_i;
        end
        if (r_fail_cnt != 8'hFF) r_fail_cnt <= r_fail_cnt + 8'd1;
      end
    end
  end

  assign fail_addr_o = r_fail_addr;
  assign fail_data_o = r_fail_data;
  assign fail_cnt_o  = r_fail_cnt;
`else
  assign fail_addr_o = '0;
  assign fail_data_o = '0;
  assign fail_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_register_file_bist_ctrl.sv
// Directed bench for register_file_bist_ctrl: a behavioural register file with injectable faults plus an op-level March C- model.
// Expected port traffic and results come from walking the March element list, not from the controller's state machine.
module tb_register_file_bist_ctrl;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NOPS = 310;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [4:0]  a;
    logic [31:0] d;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          abort_i;
  logic          busy_o, done_o, pass_o, bist_o, csn_t_o, wen_t_o;
  logic [AW-1:0] a_t_o, fail_addr_o;
  logic [DW-1:0] d_t_o, fail_data_o;
  logic [DW-1:0] q_t_i = '0;
  logic [7:0]    fail_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int fault_mode = 0;

  logic [31:0] rf_mem [32];
  op_t         ops[$];
  op_t         cur_op;

  int          m_idx  = -1;
  bit          m_done = 1'b0;
  int          e_cnt  = 0;
  logic [4:0]  e_addr = '0;
  logic [31:0] e_data = '0;

  register_file_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .bist_o      (bist_o),
    .csn_t_o     (csn_t_o),
    .wen_t_o     (wen_t_o),
    .a_t_o       (a_t_o),
    .d_t_o       (d_t_o),
    .q_t_i       (q_t_i),
    .fail_addr_o (fail_addr_o),
    .fail_data_o (fail_data_o),
    .fail_cnt_o  (fail_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural register file: the read address is registered, and writes land at the clock edge.
  always @(posedge clk) begin
    if (!csn_t_o && wen_t_o)
      q_t_i <= rf_mem[a_t_o] | ((fault_mode == 1 && a_t_o == 5'd7) ? 32'h8 : 32'h0);
    if (!csn_t_o && !wen_t_o) begin
      rf_mem[a_t_o] = d_t_o;
      if (fault_mode == 2 && a_t_o == 5'd9) rf_mem[10] = ~rf_mem[10];
    end
  end

  task automatic rf_clear();
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
  endtask

  function automatic void push_op(input bit rd, input bit wr, input int a, input logic [31:0] d);
    op_t o;
    o.rd = rd;
    o.wr = wr;
    o.a  = 5'(a);
    o.d  = d;
    ops.push_back(o);
  endfunction

  // March C-: {up W0}{up R0 W1}{up R1 W0}{down R0 W1}{down R1 W0}{down R0} over addresses 1..31.
  function automatic void build_ops();
    logic [31:0] rexp [4];
    logic [31:0] wbg  [4];
    rexp = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    wbg  = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
    for (int a = 1; a < 32; a++) push_op(0, 1, a, 32'h0);
    for (int e = 0; e < 4; e++)
      for (int k = 0; k < 31; k++) begin
        push_op(1, 0, (e < 2) ? 1 + k : 31 - k, rexp[e]);
        push_op(0, 1, (e < 2) ? 1 + k : 31 - k, wbg[e]);
      end
    for (int k = 0; k < 31; k++) push_op(1, 0, 31 - k, 32'h0);
  endfunction

  function automatic void run_model(input int mode, output int cnt, output logic [4:0] fa, output logic [31:0] fd);
    logic [31:0] mem [32];
    logic [31:0] v;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    cnt = 0;
    fa  = '0;
    fd  = '0;
    foreach (ops[i]) begin
      if (ops[i].rd) begin
        v = mem[ops[i].a] | ((mode == 1 && ops[i].a == 5'd7) ? 32'h8 : 32'h0);
        if (v != ops[i].d) begin
          if (cnt == 0) begin
            fa = ops[i].a;
            fd = v;
          end
          if (cnt < 255) cnt++;
        end
      end
      if (ops[i].wr) begin
        mem[ops[i].a] = ops[i].d;
        if (mode == 2 && ops[i].a == 5'd9) mem[10] = ~mem[10];
      end
    end
  endfunction

  // Op-level model position: index into the March trace, where index NOPS is the final compare slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx  = -1;
      m_done = 1'b0;
    end else if (m_idx >= 0) begin
      if (abort_i) m_idx = -1;
      else if (m_idx == NOPS) begin
        m_idx  = -1;
        m_done = 1'b1;
      end else m_idx++;
    end else if (start_i) begin
      m_idx  = 0;
      m_done = 1'b0;
      run_model(fault_mode, e_cnt, e_addr, e_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (!csn_t_o) chk("proto_addr_zero", 64'(a_t_o == '0), 64'd0);
      if (m_idx >= 0) begin
        chk("busy", busy_o, 1);
        chk("bist", bist_o, 1);
        chk("done_while_busy", done_o, 0);
        chk("pass_while_busy", pass_o, 0);
        if (m_idx < NOPS) begin
          cur_op = ops[m_idx];
          chk("csn", csn_t_o, 0);
          chk("wen", wen_t_o, 64'(!cur_op.wr));
          chk("addr", a_t_o, cur_op.a);
          if (cur_op.wr) chk("wdata", d_t_o, cur_op.d);
          if (m_idx == 155) chk("m3_start_addr", a_t_o, 31);
        end else begin
          chk("final_csn", csn_t_o, 1);
          chk("final_wen", wen_t_o, 1);
        end
      end else begin
        chk("idle_busy", busy_o, 0);
        chk("idle_bist", bist_o, 0);
        chk("idle_csn", csn_t_o, 1);
        chk("idle_wen", wen_t_o, 1);
        chk("idle_addr", a_t_o, 0);
        chk("idle_data", d_t_o, 0);
        chk("done", done_o, 64'(m_done));
        chk("pass", pass_o, 64'(m_done && e_cnt == 0));
`ifdef REGFILE_BIST_FAIL_LOG_EN
        if (m_done) begin
          chk("fail_cnt", fail_cnt_o, 64'(e_cnt));
          chk("fail_addr", fail_addr_o, e_addr);
          chk("fail_data", fail_data_o, e_data);
        end
`endif
      end
`ifndef REGFILE_BIST_FAIL_LOG_EN
      chk("log_tied_zero", {fail_cnt_o, fail_addr_o, fail_data_o}, 0);
`endif
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int restart_at, output int cnt);
    bit ok = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      if (busy_o) cnt++;
      start_i = (restart_at > 0 && cnt == restart_at);
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("done_timeout", ok, 1);
  endtask

  task automatic wait_busy(input int n);
    int cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy_o) cnt++;
      if (cnt == n) break;
      @(negedge clk);
    end
    chk("busy_timeout", cnt, n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_bist"}, bist_o, 0);
    chk({tag, "_csn"}, csn_t_o, 1);
    chk({tag, "_wen"}, wen_t_o, 1);
    chk({tag, "_addr"}, a_t_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_fcnt"}, fail_cnt_o, 0);
  endtask

  initial begin
    int          busy_cnt;
    int          c;
    logic [4:0]  fa;
    logic [31:0] fd;

    rst_n   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    rf_clear();
    build_ops();

    chk("model_len", ops.size(), NOPS);
    run_model(0, c, fa, fd);
    chk("model_clean_cnt", c, 0);
    run_model(1, c, fa, fd);
    chk("model_sa_cnt", c, 3);
    chk("model_sa_addr", fa, 7);
    chk("model_sa_data", fd, 32'h0000_0008);
    run_model(2, c, fa, fd);
    chk("model_cf_addr", fa, 10);

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Fault-free run, with a start pulse while busy that must be ignored.
    fault_mode = 0;
    rf_clear();
    pulse_start();
    wait_done(100, busy_cnt);
    chk("clean_busy_cycles", busy_cnt, 311);
    chk("clean_pass", pass_o, 1);
    chk("clean_fail_cnt", fail_cnt_o, 0);
    repeat (2) @(negedge clk);

    // Stuck-at-1 on bit 3 of address 7.
    fault_mode = 1;
    rf_clear();
    pulse_start();
    wait_done(0, busy_cnt);
    chk("sa_pass", pass_o, 0);
`ifdef REGFILE_BIST_FAIL_LOG_EN
    chk("sa_fail_addr", fail_addr_o, 7);
    chk("sa_fail_data", fail_data_o, 32'h0000_0008);
    chk("sa_fail_cnt", fail_cnt_o, 3);
`endif
    @(negedge clk);

    // Coupling fault: a write to address 9 flips address 10.
    fault_mode = 2;
    rf_clear();
    pulse_start();
    wait_done(0, busy_cnt);
    chk("cf_pass", pass_o, 0);
`ifdef REGFILE_BIST_FAIL_LOG_EN
    chk("cf_fail_addr", fail_addr_o, 10);
`endif
    @(negedge clk);

    // Abort mid-test, then a full clean rerun.
    fault_mode = 0;
    rf_clear();
    pulse_start();
    wait_busy(50);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_bist", bist_o, 0);
    chk("abort_done", done_o, 0);
    @(negedge clk);
    rf_clear();
    pulse_start();
    wait_done(0, busy_cnt);
    chk("rerun_busy_cycles", busy_cnt, 311);
    chk("rerun_pass", pass_o, 1);
    @(negedge clk);

    // Asynchronous reset mid-test.
    rf_clear();
    pulse_start();
    wait_busy(200);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done_o, 0);
    chk("post_rst_busy", busy_o, 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
